instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Takes each PC address, checks it against the group's 1024-word program window (0x940..0xD3F), and reads the 32-bit instruction from a synchronous instruction ROM using a local 10-bit word index.
- Buffers fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports backpressure toward the PC and a synchronous flush for future branch redirect.

Parameters:
- ADDR_W, 13, PC address width.
- DATA_W, 32, instruction width.
- BASE_ADDR, 13'h0940, first word of the program window (group 4 × 0x250).
- WIN_WORDS, 1024, window size in words; last valid address is BASE_ADDR+WIN_WORDS-1 = 0xD3F.
- IDX_W, 10, ROM index width, log2(WIN_WORDS).
- FIFO_DEPTH, 3, output buffer entries; minimum 2; 3 required for 1 instr/cycle throughput.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low: 0 resets the block immediately; released synchronously by the integrator.
- pc_addr  in  ADDR_W  address from the PC.
- pc_valid  in  1  pc_addr is valid.
- pc_ready  out  1  fetch accepts pc_addr this cycle; wired to the PC's hold/enable.
- flush  in  1  synchronous discard of all buffered and in-flight fetches.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  IDX_W  ROM word index.
- rom_data  in  DATA_W  ROM read data, valid exactly one cycle after rom_en.
- instr  out  DATA_W  instruction to decode.
- instr_addr  out  ADDR_W  PC address of instr.
- instr_fault  out  1  instr came from an out-of-window address.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes the head.

Behaviour:
- Acceptance:
  - accept = pc_valid && pc_ready.
  - pc_ready = !flush && (fifo_count + inflight) < FIFO_DEPTH. This is combinational from registered state and flush only; it never depends on instr_ready.
- In-window access (BASE_ADDR <= pc_addr <= BASE_ADDR+WIN_WORDS-1):
  - rom_en=1 and rom_addr=pc_addr-BASE_ADDR (low IDX_W bits) in the accept cycle.
  - Otherwise rom_en=0 and rom_addr=0.
- Out-of-window access:
  - No ROM read.
  - The entry still occupies a slot and follows identical timing, with instr=32'h0000_0000 (NOP) and instr_fault=1.
- In-flight stage:
  - One register stage (inflight flag, address, fault) captures the accepted request.
  - On the next cycle the entry is written to the FIFO with rom_data (or NOP if faulted).
- Latency: accept at cycle N → instr_valid at N+2 when the FIFO is empty. With instr_ready held at 1, sustained throughput is 1 instr/cycle.
- Pop: instr_valid && instr_ready. Push and pop in the same cycle are legal at any occupancy, and count is unchanged.
- Ordering and stability:
  - Entries are delivered strictly in acceptance order.
  - instr, instr_addr and instr_fault are the FIFO head and stay stable while instr_valid=1 and instr_ready=0.
- Full FIFO: pc_ready=0. No entry is ever dropped or overwritten.
- Flush (takes priority over push, pop and accept):
  - In the flush cycle pc_ready=0, so no accept occurs.
  - Next cycle fifo_count=0, inflight=0 and instr_valid=0.
  - rom_data for a read issued before the flush is ignored.
- Window wrap: 0xD3F followed by 0x940 produces rom_addr 0x3FF then 0x000, with no special handling.
- Reset asserted (reset=0):
  - Immediately, with no clock: fifo_count=0, inflight=0, instr_valid=0, instr=0, instr_addr=0, instr_fault=0.
  - pc_ready is forced to 0 and rom_en to 0.
  - If asserted mid-operation, in-flight data is lost.
  - After release, pc_ready=1 in the first cycle.
- Width rules:
  - All comparisons and the subtraction are unsigned at ADDR_W.
  - The FIFO count is clog2(FIFO_DEPTH+1) bits.

Decomposition:
- Package fetch_pkg:
  - ADDR_W, DATA_W, IDX_W.
  - BASE_ADDR and LAST_ADDR (0x940, 0xD3F).
  - NOP_INSTR (32'h0).
  - The fifo entry struct {addr, fault, data}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO: push/pop/flush, count output, head data output.
  - Same clk and active-low asynchronous reset.
- The top handles the window check, ROM request, in-flight stage and credit logic.

Test Plan:
1. Reset release, then a stream 0x940, 0x941, 0x942 with pc_valid=1 and instr_ready=1 → rom_addr 0x000, 0x001, 0x002; first instr_valid 2 cycles after acceptance with instr_addr=0x940 and instr=rom[0]; then one instruction per cycle, in order.
2. Wrap: 0xD3E, 0xD3F, 0x940 → rom_addr 0x3FE, 0x3FF, 0x000; instr_fault=0 on all three.
3. Out-of-window 0x93F and 0xD40 → rom_en=0; entries delivered with instr=0, instr_fault=1 and correct instr_addr.
4. Backpressure, instr_ready=0:
   - pc_ready drops after 3 accepts and instr stays stable at the 0x940 entry.
   - Raise instr_ready → all 3 drain in order and pc_ready returns to 1.
5. Flush with 2 FIFO entries plus 1 read in flight → next cycle instr_valid=0; no stale entry appears afterward even though rom_data arrives; the next accepted address appears 2 cycles later.
6. Reset driven low mid-stream, between clock edges → instr_valid, pc_ready and rom_en go to 0 immediately; after release, fetch restarts cleanly from the new pc_addr.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, program-window constants and the FIFO entry layout for the fetch stage.
// Window: 1024 words starting at 0x940, so the last fetchable word is 0xD3F.
// Entry: PC address, out-of-window fault flag and the 32-bit instruction word.
package fetch_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 10;
    localparam int WIN_WORDS = 1024;

    localparam logic [ADDR_W-1:0] BASE_ADDR = 13'h0940;
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(WIN_WORDS - 1);

    // Substituted for out-of-window fetches.
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              fault;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small synchronous FIFO with flush; head entry and occupancy count exported.
// Latency: a push is visible at the head one cycle later; push and pop may share a cycle.
// Backpressure: the producer must respect count; a push into a full FIFO without a pop is dropped.
// Ports: clk, reset (async active-low), flush, push_vld/push_dat, pop, count, head_vld/head_dat.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type dat_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_vld,
    input  dat_t                         push_dat,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_vld,
    output dat_t                         head_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    dat_t             mem_q [DEPTH];
    dat_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push_vld && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Purpose: window-check PC addresses, read the instruction ROM and buffer results for decode.
// Latency: accept in cycle N -> instr_valid in N+2 when empty; sustains 1 instr/cycle.
// Backpressure: pc_ready counts FIFO entries plus the in-flight read; it never looks at instr_ready.
// Ports: clk, reset (async active-low), pc_addr/pc_valid/pc_ready, flush,
//        rom_en/rom_addr/rom_data, instr/instr_addr/instr_fault/instr_valid/instr_ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              rom_en,
    output logic [IDX_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_fault,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d;
    logic              if_fault_q, if_fault_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic [ADDR_W-1:0] win_offset;
    logic              in_window;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              head_vld;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    always_comb begin
        // Unsigned subtraction: addresses below BASE_ADDR wrap to large offsets,
        // so one compare covers both window edges.
        win_offset = pc_addr - BASE_ADDR;
        in_window  = (win_offset <= (LAST_ADDR - BASE_ADDR));

        // The in-flight read already owns a FIFO slot, so it is counted as occupancy.
        occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_q);
        pc_ready   = reset && !flush && (occupancy < OCC_W'(FIFO_DEPTH));
        accept     = pc_valid && pc_ready;

        rom_en     = accept && in_window;
        rom_addr   = rom_en ? win_offset[IDX_W-1:0] : '0;

        // Flush already blocks accept, which also clears the in-flight flag.
        inflight_d = accept;
        if_addr_d  = accept ? pc_addr : if_addr_q;
        if_fault_d = accept ? !in_window : if_fault_q;

        fifo_push        = inflight_q && !flush;
        push_entry.addr  = if_addr_q;
        push_entry.fault = if_fault_q;
        push_entry.data  = if_fault_q ? NOP_INSTR : rom_data;

        fifo_pop   = head_vld && instr_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            if_addr_q  <= '0;
            if_fault_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if_addr_q  <= if_addr_d;
            if_fault_q <= if_fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .dat_t (fetch_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push_vld (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .count    (fifo_count),
        .head_vld (head_vld),
        .head_dat (head_entry)
    );

    assign instr       = head_entry.data;
    assign instr_addr  = head_entry.addr;
    assign instr_fault = head_entry.fault;
    assign instr_valid = head_vld;

endmodule
